// File: rtl/shift_add_multiplier_pkg.sv
// ============================================================================
// Module  : shift_add_multiplier_pkg
// Brief   : Shared FSM state encoding and width helper for the sequential
//           shift-and-add multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_add_multiplier_pkg;

    // Controller state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the step counter
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/n_full_adder.sv
// ============================================================================
// Module  : n_full_adder
// Brief   : n-bit ripple-carry adder built from a chain of full-adder cells.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module n_full_adder #(
    parameter int n = 8
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic [n-1:0] sum
);

    // carry[i] is the carry into bit i
    logic [n-1:0] w_carry;

    assign w_carry[0] = cin;

    // One full-adder cell per bit; the last cell's carry-out is not needed
    // because callers size the adder one bit wider than their operands.
    for (genvar i = 0; i < n; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ w_carry[i];
        if (i < n - 1) begin : g_carry
            assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_add_multiplier.sv
// ============================================================================
// Module  : shift_add_multiplier
// Brief   : Sequential N x N unsigned shift-and-add multiplier. One add/shift
//           step per clock through a single (N+1)-bit ripple adder; 2N-bit
//           product after N steps, with a start/done handshake.
//           Optional: SHIFT_ADD_ZERO_BYPASS_EN - a zero operand skips RUN and
//           completes in one cycle with product 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = clog2(N) + 1;

    state_t          state_q, state_d;
    logic [N-1:0]    m_q, m_d;
    logic [N-1:0]    q_q, q_d;
    logic [N-1:0]    acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2*N-1:0]  product_q, product_d;

    logic [N-1:0]    w_addend;
    logic [N:0]      w_sum;

    // Partial product selected by the current multiplier LSB
    assign w_addend = q_q[0] ? m_q : {N{1'b0}};

    n_full_adder #(
        .n (N + 1)
    ) u_adder (
        .a   ({1'b0, acc_q}),
        .b   ({1'b0, w_addend}),
        .cin (1'b0),
        .sum (w_sum)
    );

    // Next-state and datapath update for the add/shift controller
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    count_d = '0;
                    state_d = ST_RUN;
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
                    if ((a == '0) || (b == '0)) begin
                        product_d = '0;
                        state_d   = ST_DONE;
                    end
`endif
                end
            end
            ST_RUN: begin
                // Right shift of {carry, acc, Q}: the adder's carry becomes
                // the new MSB and the retired multiplier bit drops out.
                {acc_d, q_d} = {w_sum, q_q[N-1:1]};
                count_d      = count_q + CW'(1);
                if (count_q == CW'(N - 1)) begin
                    product_d = {w_sum, q_q[N-1:1]};
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_add_multiplier.sv
// ============================================================================
// Module  : tb_shift_add_multiplier
// Brief   : Self-checking bench for shift_add_multiplier (N=8). Directed
//           cases plus randomized operands against an arithmetic reference.
//           Honours SHIFT_ADD_ZERO_BYPASS_EN when defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shift_add_multiplier;

    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*N-1:0] product;

    int n_checks;
    int n_fail;

    shift_add_multiplier #(
        .N (N)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Reference: edges (counting the accepting edge) until done is visible
    function automatic int ref_latency(input logic [N-1:0] ra, input logic [N-1:0] rb);
`ifdef SHIFT_ADD_ZERO_BYPASS_EN
        if ((ra == 0) || (rb == 0)) return 1;
`endif
        return N + 1;
    endfunction

    // Issue one multiply from IDLE and check latency, busy span, result, pulse width
    task automatic run_mul(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tbv);
        int lat;
        int busy_cycles;
        bit seen;
        logic [2*N-1:0] exp_p;
        exp_p = 16'(ta) * 16'(tbv);
        @(negedge clk);
        a = ta;
        b = tbv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        busy_cycles = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(ref_latency(ta, tbv)));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(ref_latency(ta, tbv) - 1));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        check({tag, "_product"}, 32'(product), 32'(exp_p));
        @(posedge clk);
        #1;
        check({tag, "_done_pulse_1cyc"}, 32'(done), 32'd0);
        check({tag, "_product_hold"}, 32'(product), 32'(exp_p));
    endtask

    initial begin
        int dones;
        int last_done;
        logic [N-1:0] ra;
        logic [N-1:0] rb;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_mul("m123x123", 8'd123, 8'd123);
        run_mul("m255x255", 8'd255, 8'd255);
        run_mul("m0x77", 8'd0, 8'd77);
        run_mul("m77x0", 8'd77, 8'd0);
        run_mul("m1x1", 8'd1, 8'd1);

        // Start pulses during RUN must be ignored
        @(negedge clk);
        a = 8'd3;
        b = 8'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'd5;
        b = 8'd5;
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                check("run_ignore_product", 32'(product), 32'd12);
            end
        end
        check("run_ignore_done_count", 32'(dones), 32'd1);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'd200;
        b = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_product", 32'(product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_mul("m6x7", 8'd6, 8'd7);

        // start held high: one result every N+2 cycles
        @(negedge clk);
        a = 8'd10;
        b = 8'd20;
        start = 1'b1;
        dones = 0;
        last_done = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                check("held_product", 32'(product), 32'd200);
                if (last_done < 0) check("held_first_latency", 32'(k), 32'(N + 1));
                else               check("held_interval", 32'(k - last_done), 32'(N + 2));
                last_done = k;
            end
        end
        check("held_done_count", 32'(dones), 32'd6);
        @(negedge clk);
        start = 1'b0;
        repeat (N + 3) @(posedge clk);

        // Randomized operands against the arithmetic reference
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            run_mul("rand", ra, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
